// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to TX and RX),
// bit-period arithmetic and counter sizing helpers.
package uart_pkg;

   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] uart_state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // PCLK cycles per line bit; truncating division, never below one cycle.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      int cpb;
      cpb = clk_freq / baud_rate;
      if (cpb < 1) cpb = 1;
      return cpb;
   endfunction

   // Bits needed to hold the values 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Line bits per frame: start + data + optional parity + stop.
   function automatic int frame_bits(input int data_bits, input bit parity_en);
      return data_bits + 2 + (parity_en ? 1 : 0);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: cleared at frame start, counts PCLK cycles while
// enabled and pulses tick on the last cycle of every bit period.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int               CNT_W    = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && !clear && (count == CNT_LAST);

   // Period counter: wraps to zero on the terminal count so each bit lasts CLKS_PER_BIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == CNT_LAST) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, one stop bit. Optional parity is built only when the macro
// UART_TX_PARITY_EN is defined; PARITY_ODD selects odd parity then.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | line high, waiting for tx_start
// ST_START   | driving the start bit (low)
// ST_DATA    | driving data bit bit_idx from shift_reg[0]
// ST_PARITY  | driving the parity bit (parity build only)
// ST_STOP    | driving the stop bit (high); tx_done on completion
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = 9600,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int               BIT_W        = cnt_width(DATA_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_BITS - 1);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [BIT_W-1:0]     bit_idx;
   logic                 accept;
   logic                 bit_tick;

   // A request is only seen in IDLE, so a start while busy is simply dropped.
   assign accept = (state == ST_IDLE) && tx_start;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_tick (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .clear  (accept),
      .enable (state != ST_IDLE),
      .tick   (bit_tick)
   );

`ifdef UART_TX_PARITY_EN
   logic parity_bit;

   // Parity is taken from the byte as captured, so later tx_data changes cannot affect it.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         parity_bit <= 1'b0;
      end else if (accept) begin
         parity_bit <= (^tx_data) ^ (PARITY_ODD != 0);
      end
   end
`else
   // Without parity the sense parameter and the parity state code are inert.
   logic unused_parity_cfg;
   assign unused_parity_cfg = (PARITY_ODD != 0) ^ (|ST_PARITY);
`endif

   // Frame sequencer: line level, shift register and handshake outputs are all registered.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         tx_serial <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               tx_serial <= 1'b1;
               if (tx_start) begin
                  shift_reg <= tx_data;
                  bit_idx   <= '0;
                  tx_serial <= 1'b0;
                  tx_busy   <= 1'b1;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (bit_tick) begin
                  tx_serial <= shift_reg[0];
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     tx_serial <= parity_bit;
                     state     <= ST_PARITY;
`else
                     tx_serial <= 1'b1;
                     state     <= ST_STOP;
`endif
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     tx_serial <= shift_reg[1];
                     bit_idx   <= bit_idx + BIT_W'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  tx_serial <= 1'b1;
                  state     <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               if (bit_tick) begin
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               tx_serial <= 1'b1;
               tx_busy   <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the APB UART IP; the upstream counterpart of UART_RX.
- Accepts a parallel byte from the APB register block via a start/busy handshake.
- Serialises it onto tx_serial as start bit, data bits (LSB first), optional parity bit and stop bit, at BAUD_RATE.
- In loopback benches tx_serial drives UART_RX.rx_serial directly.

Parameters:
- BAUD_RATE, 9600, line bit rate in bits/s.
- CLK_FREQ, 100_000_000, PCLK frequency in Hz.
- DATA_BITS, 8, data bits per frame (legal range 5..9).
- PARITY_ODD, 0, parity sense when UART_TX_PARITY_EN is defined: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- PCLK  input  1  system clock; all state is rising-edge.
- PRESETn  input  1  asynchronous active-low reset.
- tx_start  input  1  request to send tx_data; sampled only while tx_busy=0.
- tx_data  input  DATA_BITS  byte to send; captured on the accepting edge.
- tx_serial  output  1  UART line; idles high.
- tx_busy  output  1  high from the accepting edge until the end of the stop bit.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Interface: one clock (PCLK); reset PRESETn is asynchronous, active-low.
- Reset values: tx_serial=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0, shift register=0.
  - Reset asserted mid-frame returns tx_serial to 1 immediately (asynchronously).
  - The frame is abandoned; no tx_done is issued.
- CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division (10416 at defaults).
  - The baud counter is wide enough for CLKS_PER_BIT-1.
  - Every bit is held for exactly CLKS_PER_BIT PCLK cycles.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE:
  - tx_serial=1, tx_busy=0.
  - On an edge with tx_start=1: latch tx_data into the shift register, drive tx_serial=0, set tx_busy=1, clear baud and bit counters, go to START.
  - Latency from the tx_start edge to the falling line is 0 cycles; the line changes on that same edge.
- START: after CLKS_PER_BIT cycles, drive data bit 0, go to DATA.
- DATA:
  - Each CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After bit DATA_BITS-1 completes, go to PARITY (if enabled) or STOP, and drive the corresponding line level.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - On the final cycle edge: tx_busy goes to 0, tx_done=1 for exactly one cycle, return to IDLE.
- Frame length = (DATA_BITS+2)*CLKS_PER_BIT cycles, or +1 bit time with parity.
- tx_start while tx_busy=1 is ignored. There is no queue, and tx_data changes are not observed.
- Back-to-back frames: tx_start held high on the tx_done cycle is not accepted that edge.
  - It is accepted on the next edge, giving one idle cycle of line high between frames.
- tx_done and tx_busy never assert together.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - The parity bit equals XOR of the captured data, inverted when PARITY_ODD=1.
  - The parity bit is held for CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; DATA goes directly to STOP. PARITY_ODD has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (shared with UART_RX);
  - the CLKS_PER_BIT computation function;
  - the counter width function (clog2).
- One sub-module, uart_baud_tick: a counter that is cleared on frame start and pulses a tick every CLKS_PER_BIT cycles. UART_RX can reuse it.
- The FSM and shift register stay in uart_tx.

Test Plan:
- Send 0x0F at defaults; sample tx_serial at mid-bit (k*10416+5208 cycles) → 0,1,1,1,1,0,0,0,0,1. tx_busy high for 104160 cycles, then tx_done is a single pulse.
- Loopback into UART_RX, sending 0xEE then 0xCD back-to-back with tx_start held → rx_data 0xEE then 0xCD, rx_ready twice, frame_error never set. The gap between frames is exactly 1 idle cycle.
- Pulse tx_start with 0x55 at cycle 3000 of a 0xA3 frame → the 0xA3 frame is unaltered, 0x55 is never sent, tx_done fires exactly once.
- Assert PRESETn=0 during data bit 4 of 0xF0 → tx_serial=1 within the same timestep, tx_busy=0, no tx_done. A new 0x3C after release is transmitted correctly.
- With UART_TX_PARITY_EN and PARITY_ODD=0, send 0xCD → parity bit = 1 (popcount 5). With PARITY_ODD=1 → parity bit = 0. Frame is 11 bit times.
- With CLK_FREQ=1_000_000 and BAUD_RATE=115200 (CLKS_PER_BIT=8, truncated), send 0x81 → each bit is exactly 8 cycles, frame is 80 cycles.
